// File: rtl/cam_pkg.sv
// Shared types and widths for the camera frame-buffer writer.
package cam_pkg;

  localparam int COORD_W = 10;
  localparam int PIX_W   = 8;
  localparam int CNT_W   = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SYNC,
    S_CAPTURE
  } fbw_state_t;

endpackage

// File: rtl/cam_fb_writer_if.sv
// Capture-stream inputs and frame-buffer write/status outputs of cam_fb_writer.
interface cam_fb_writer_if
  import cam_pkg::*;
#(
  parameter int ADDR_W = 17
);

  logic                capture_en;
  logic [COORD_W-1:0]  x_coord;
  logic [COORD_W-1:0]  y_coord;
  logic [PIX_W-1:0]    pixel_data;

  logic                fb_we;
  logic [ADDR_W-1:0]   fb_addr;
  logic [PIX_W-1:0]    fb_wdata;
  logic                fb_bank;
  logic                rd_bank;
  logic                frame_done;
  logic [CNT_W-1:0]    frame_cnt;

  modport master (
    output capture_en, x_coord, y_coord, pixel_data,
    input  fb_we, fb_addr, fb_wdata, fb_bank, rd_bank, frame_done, frame_cnt
  );

  modport slave (
    input  capture_en, x_coord, y_coord, pixel_data,
    output fb_we, fb_addr, fb_wdata, fb_bank, rd_bank, frame_done, frame_cnt
  );

endinterface

// File: rtl/cam_coord_evt.sv
// Registers the previous coordinates and derives pixel / frame-wrap events from them.
module cam_coord_evt
  import cam_pkg::*;
(
  input  logic               pclk,
  input  logic               reset,
  input  logic [COORD_W-1:0] x_coord,
  input  logic [COORD_W-1:0] y_coord,
  output logic               pix_evt,
  output logic               frame_evt,
  output logic [COORD_W-1:0] x_prev,
  output logic [COORD_W-1:0] y_prev
);

  always_ff @(posedge pclk) begin
    if (reset) begin
      x_prev <= '0;
      y_prev <= '0;
    end else begin
      x_prev <= x_coord;
      y_prev <= y_coord;
    end
  end

  always_comb begin
    pix_evt   = (x_coord == x_prev + COORD_W'(1));
    frame_evt = (y_coord == '0) && (y_prev != '0);
  end

endmodule

// File: rtl/cam_fb_writer.sv
// Ping-pong frame-buffer writer driven by inferred pixel/frame events.
// Optional CAM_FB_DOWNSAMPLE_EN: store only even columns/lines at half resolution.
module cam_fb_writer
  import cam_pkg::*;
#(
  parameter int FB_W = 320,
  parameter int FB_H = 240
) (
  input logic            pclk,
  input logic            reset,
  cam_fb_writer_if.slave bus
);

  localparam int ADDR_W = $clog2(FB_W * FB_H);

  fbw_state_t         state, state_nx;
  logic               pix_evt, frame_evt;
  logic [COORD_W-1:0] x_prev, y_prev, xs, ys;
  logic               keep, in_win, wr_en, done_nx;
  logic [ADDR_W-1:0]  addr_nx;

  logic               fb_we, fb_bank, frame_done;
  logic [ADDR_W-1:0]  fb_addr;
  logic [PIX_W-1:0]   fb_wdata;
  logic [CNT_W-1:0]   frame_cnt;

  cam_coord_evt u_evt (
    .pclk      (pclk),
    .reset     (reset),
    .x_coord   (bus.x_coord),
    .y_coord   (bus.y_coord),
    .pix_evt   (pix_evt),
    .frame_evt (frame_evt),
    .x_prev    (x_prev),
    .y_prev    (y_prev)
  );

  // The completed pixel is the one at (x_prev, y_prev); map it into the stored frame.
  always_comb begin
`ifdef CAM_FB_DOWNSAMPLE_EN
    xs   = x_prev >> 1;
    ys   = y_prev >> 1;
    keep = !x_prev[0] && !y_prev[0];
`else
    xs   = x_prev;
    ys   = y_prev;
    keep = 1'b1;
`endif
    in_win  = keep && (int'(xs) < FB_W) && (int'(ys) < FB_H);
    addr_nx = ADDR_W'(ys) * ADDR_W'(FB_W) + ADDR_W'(xs);
  end

  always_comb begin
    state_nx = state;
    wr_en    = 1'b0;
    done_nx  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (bus.capture_en) state_nx = S_SYNC;
      end
      S_SYNC: begin
        if (!bus.capture_en)  state_nx = S_IDLE;
        else if (frame_evt)   state_nx = S_CAPTURE;
      end
      S_CAPTURE: begin
        // A frame wrap takes priority over a coincident pixel event.
        if (frame_evt) begin
          done_nx = 1'b1;
          if (!bus.capture_en) state_nx = S_IDLE;
        end else if (pix_evt && in_win) begin
          wr_en = 1'b1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      state      <= S_IDLE;
      fb_we      <= 1'b0;
      fb_addr    <= '0;
      fb_wdata   <= '0;
      fb_bank    <= 1'b0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      state      <= state_nx;
      fb_we      <= wr_en;
      frame_done <= done_nx;
      if (wr_en) begin
        fb_addr  <= addr_nx;
        fb_wdata <= bus.pixel_data;
      end
      if (done_nx) begin
        fb_bank   <= ~fb_bank;
        frame_cnt <= frame_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.fb_we      = fb_we;
  assign bus.fb_addr    = fb_addr;
  assign bus.fb_wdata   = fb_wdata;
  assign bus.fb_bank    = fb_bank;
  assign bus.rd_bank    = ~fb_bank;
  assign bus.frame_done = frame_done;
  assign bus.frame_cnt  = frame_cnt;

endmodule
